// File: rtl/pipe_mem_ctrl.sv
// pipe_mem_ctrl: memory-port arbiter and pipeline stall merger for the 5-stage core.
//
// Arbitrates a single external bus between instruction fetch (IF) and load/store (LS).
// LS has strict priority. Each transaction holds the bus_* outputs stable until bus_ready
// is sampled high. The transaction then completes with a one-cycle *_done pulse and the
// registered read data.
//
// A fetch that sees br_flush while on the bus is discarded: no if_done, if_rdata kept.
// The stall vector is combinational: [0]=PC [1]=IF_ID [2]=ID_EX [3]=EX_MEM [4]=MEM_WB [5]=WB.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a transaction after TIMEOUT_CYC cycles
// without bus_ready. The abort returns *_rdata = 0 and sets the sticky bus_err flag.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request (held until if_done)
//   if_rdata/if_done              fetched word, completion pulse
//   ls_req/ls_we/ls_addr/
//     ls_wdata/ls_wmask           load/store request (held until ls_done)
//   ls_rdata/ls_done              load word, completion pulse
//   id_stall_req, br_flush        load-use hazard, taken branch/jump
//   bus_valid/we/addr/wdata/wmask bus request outputs (registered)
//   bus_rdata/bus_ready           bus response inputs
//   stall                         per-stage stall vector
//   bus_err                       sticky timeout flag (0 without MEM_TIMEOUT_EN)
module pipe_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wmask,
  output logic [31:0] ls_rdata,
  output logic        ls_done,
  input  logic        id_stall_req,
  input  logic        br_flush,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic [5:0]  stall,
  output logic        bus_err
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIfBus = 2'd1;
  localparam logic [1:0] StLsBus = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        bus_valid_q, bus_valid_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wmask_q, bus_wmask_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        if_done_q, if_done_d;
  logic        ls_done_q, ls_done_d;
  logic        discard_q, discard_d;
  logic        flush_now;
  logic        abort;

`ifdef MEM_TIMEOUT_EN
  // Abort on the TIMEOUT_CYC-th consecutive busy cycle without bus_ready.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       bus_err_q, bus_err_d;

  always_comb begin
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    abort     = 1'b0;
    if (state_q == StIdle) begin
      cnt_d = 8'd0;
    end else if (!bus_ready) begin
      if (cnt_q == TimeoutLast) begin
        abort     = 1'b1;
        bus_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wmask_d = bus_wmask_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    discard_d   = discard_q;
    // A flush in the completing cycle counts as well.
    flush_now   = discard_q | br_flush;
    case (state_q)
      StIdle: begin
        discard_d = 1'b0;
        // *_done_q blocks re-granting a requester in its own done cycle.
        if (ls_req && !ls_done_q) begin
          state_d     = StLsBus;
          bus_valid_d = 1'b1;
          bus_we_d    = ls_we;
          bus_addr_d  = ls_addr;
          bus_wdata_d = ls_wdata;
          bus_wmask_d = ls_wmask;
        end else if (if_req && !if_done_q && !br_flush) begin
          state_d     = StIfBus;
          bus_valid_d = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wmask_d = 4'hF;
        end
      end
      StIfBus: begin
        if (bus_ready || abort) begin
          state_d     = StIdle;
          bus_valid_d = 1'b0;
          discard_d   = 1'b0;
          if (!flush_now) begin
            if_done_d  = 1'b1;
            if_rdata_d = abort ? 32'd0 : bus_rdata;
          end
        end else begin
          discard_d = flush_now;
        end
      end
      StLsBus: begin
        if (bus_ready || abort) begin
          state_d     = StIdle;
          bus_valid_d = 1'b0;
          ls_done_d   = 1'b1;
          if (abort) begin
            ls_rdata_d = 32'd0;
          end else if (!bus_we_q) begin
            ls_rdata_d = bus_rdata;
          end
        end
      end
      default: begin
        state_d     = StIdle;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_wmask_q <= 4'd0;
      if_rdata_q  <= 32'd0;
      ls_rdata_q  <= 32'd0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wmask_q <= bus_wmask_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      discard_q   <= discard_d;
    end
  end

  // LS stalls everything up to MEM_WB; load-use bubbles ID_EX; fetch holds PC and IF_ID.
  always_comb begin
    if (ls_req && !ls_done_q) begin
      stall = 6'b011111;
    end else if (id_stall_req) begin
      stall = 6'b000111;
    end else if (if_req && !if_done_q) begin
      stall = 6'b000011;
    end else begin
      stall = 6'b000000;
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wmask = bus_wmask_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign if_done   = if_done_q;
  assign ls_done   = ls_done_q;

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Self-checking bench for pipe_mem_ctrl: directed test-plan cases followed by randomized
// requesters and a random-latency memory. Expected values come from a transaction-level
// model of the arbitration rules.
module tb_pipe_mem_ctrl;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wmask;
  logic [31:0] ls_rdata;
  logic        ls_done;
  logic        id_stall_req;
  logic        br_flush;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [5:0]  stall;
  logic        bus_err;

  pipe_mem_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_rdata(ls_rdata), .ls_done(ls_done),
    .id_stall_req(id_stall_req), .br_flush(br_flush),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wmask(bus_wmask), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .stall(stall), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the bus, what it presented, what completes when.
  int          m_owner;  // 0 none, 1 fetch, 2 load/store
  bit          m_disc;
  int          m_wait;
  bit          m_if_done, m_ls_done, m_we, m_err;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_ls_rdata;
  logic [3:0]  m_wmask;
  int          n_done = 0;

  task automatic model_step();
    bit nxt_if_done, nxt_ls_done, flushed, timed_out;
    nxt_if_done = 1'b0;
    nxt_ls_done = 1'b0;
    if (rst) begin
      m_owner = 0; m_disc = 0; m_wait = 0; m_we = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_wmask = '0; m_if_rdata = '0; m_ls_rdata = '0;
      m_if_done = 0; m_ls_done = 0;
      return;
    end
    if (m_owner == 0) begin
      m_wait = 0;
      m_disc = 0;
      if (ls_req && !m_ls_done) begin
        m_owner = 2; m_we = ls_we; m_addr = ls_addr; m_wdata = ls_wdata; m_wmask = ls_wmask;
      end else if (if_req && !m_if_done && !br_flush) begin
        m_owner = 1; m_we = 0; m_addr = if_addr; m_wmask = 4'hF;
      end
    end else begin
      flushed = m_disc || (m_owner == 1 && br_flush);
`ifdef MEM_TIMEOUT_EN
      timed_out = !bus_ready && (m_wait + 1 == int'(TO));
`else
      timed_out = 1'b0;
`endif
      if (bus_ready || timed_out) begin
        n_done++;
        if (timed_out) m_err = 1;
        if (m_owner == 2) begin
          nxt_ls_done = 1;
          if (timed_out) m_ls_rdata = 32'd0;
          else if (!m_we) m_ls_rdata = bus_rdata;
        end else if (!flushed) begin
          nxt_if_done = 1;
          m_if_rdata  = timed_out ? 32'd0 : bus_rdata;
        end
        m_owner = 0;
        m_disc  = 0;
      end else begin
        m_wait++;
        m_disc = flushed;
      end
    end
    m_if_done = nxt_if_done;
    m_ls_done = nxt_ls_done;
  endtask

  task automatic check_outputs();
    check("bus_valid", bus_valid, m_owner != 0);
    check("bus_we", bus_we, m_we);
    check("bus_addr", bus_addr, m_addr);
    check("bus_wdata", bus_wdata, m_wdata);
    check("bus_wmask", bus_wmask, m_wmask);
    check("if_done", if_done, m_if_done);
    check("ls_done", ls_done, m_ls_done);
    check("if_rdata", if_rdata, m_if_rdata);
    check("ls_rdata", ls_rdata, m_ls_rdata);
    check("bus_err", bus_err, m_err);
  endtask

  task automatic check_stall();
    logic [5:0] exp;
    if (ls_req && !m_ls_done) exp = 6'b011111;
    else if (id_stall_req) exp = 6'b000111;
    else if (if_req && !m_if_done) exp = 6'b000011;
    else exp = 6'b000000;
    check("stall", stall, exp);
  endtask

  // Called at a negedge after inputs are set: check stall, run one clock, check outputs.
  task automatic step();
    #1 check_stall();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic new_ls();
    ls_we    = 1'($urandom_range(0, 1));
    ls_addr  = $urandom & 32'hFFFF_FFFC;
    ls_wdata = $urandom;
    ls_wmask = 4'($urandom_range(1, 15));
  endtask

  task automatic drive_random(input int ready_pct);
    rst = ($urandom_range(0, 299) == 0);
    if (!if_req) begin
      if ($urandom_range(0, 1) == 1) begin
        if_req  = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
    end else if (m_if_done) begin
      if ($urandom_range(0, 1) == 1) if_req = 1'b0;
      else if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!ls_req) begin
      if ($urandom_range(0, 2) == 0) begin
        ls_req = 1'b1;
        new_ls();
      end
    end else if (m_ls_done) begin
      if ($urandom_range(0, 1) == 1) ls_req = 1'b0;
      else new_ls();
    end
    br_flush = ($urandom_range(0, 7) == 0);
    // A taken branch redirects the fetch address.
    if (br_flush && if_req && !m_if_done) if_addr = $urandom & 32'hFFFF_FFFC;
    id_stall_req = ($urandom_range(0, 3) == 0);
    bus_ready    = ($urandom_range(0, 99) < ready_pct);
    bus_rdata    = $urandom;
  endtask

  initial begin
    rst = 1'b1; if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0;
    ls_wdata = '0; ls_wmask = '0; id_stall_req = 0; br_flush = 0;
    bus_rdata = '0; bus_ready = 0;
    step();
    step();
    check("rst_bus_valid", bus_valid, 1'b0);
    check("rst_bus_wmask", bus_wmask, 4'h0);

    // Zero-wait fetch: request, valid, done.
    rst = 0; if_req = 1; if_addr = 32'h100; bus_ready = 1; bus_rdata = 32'h13;
    #1 check("tp_fetch_stall", stall, 6'b000011);
    step();
    check("tp_fetch_valid", bus_valid, 1'b1);
    check("tp_fetch_addr", bus_addr, 32'h100);
    step();
    check("tp_fetch_done", if_done, 1'b1);
    check("tp_fetch_rdata", if_rdata, 32'h13);
    if_req = 0; bus_ready = 0;
    #1 check("tp_fetch_stall_done", stall, 6'b000000);

    // Load-use bubble with no LS pending.
    id_stall_req = 1;
    #1 check("tp_load_use", stall, 6'b000111);
    step();
    id_stall_req = 0;

    // Random traffic with decreasing memory speed.
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 1000; c++) begin
        drive_random(ph == 0 ? 100 : (ph == 1 ? 50 : 20));
        step();
      end
    end

    check("progress", n_done > 100, 1'b1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
